// File: rtl/pcie_perst_seq_pkg.sv
// Shared encodings for the PERST# sequencer: FSM state values and event counter limits.
package pcie_perst_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_SETTLE    = 2'b10,
    ST_RUN       = 2'b11
  } seq_state_e;

  localparam int               EVT_W   = 8;
  localparam logic [EVT_W-1:0] EVT_SAT = 8'hFF;

endpackage

// File: rtl/pcie_sync_debounce.sv
// Async input synchroniser with a high-side debounce filter; a low passes through
// one cycle after the sync chain, a high must persist DEBOUNCE_CYCLES (0 = sync only).
module pcie_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic in_dat,
  output logic out_dat
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_dat;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], in_dat};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) sync_q <= '0;
    else             sync_q <= sync_d;
  end

  assign sync_dat = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign out_dat = sync_dat;
  end else begin : g_debounce
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            deb_q, deb_d;

    // Count saturates once accepted so a long-high input never re-triggers.
    always_comb begin
      db_cnt_d = db_cnt_q;
      deb_d    = deb_q;
      if (!sync_dat) begin
        db_cnt_d = '0;
        deb_d    = 1'b0;
      end else if (db_cnt_q == DB_LAST) begin
        deb_d = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        db_cnt_q <= '0;
        deb_q    <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        deb_q    <= deb_d;
      end
    end

    assign out_dat = deb_q;
  end

endmodule

// File: rtl/pcie_perst_sequencer.sv
// Sequences PCIe PERST# release behind debounced request, PLL lock and minimum hold.
// Assertion reaches the outputs within SYNC_STAGES+3 edges; release is fully timed.
module pcie_perst_sequencer
  import pcie_perst_seq_pkg::*;
#(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 1024,
  parameter int MIN_ASSERT_CYCLES    = 100000,
  parameter int REFCLK_STABLE_CYCLES = 10000,
  parameter int CNT_W                = 24
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               perst_pin_n,
  input  logic               gpio_perst_n,
  input  logic               refclk_locked,
  output logic               pin_perst_n_reset_n,
  output logic               i_gpio_perst0_n_reset_n,
  output logic [STATE_W-1:0] seq_state,
  output logic [EVT_W-1:0]   perst_event_cnt
);

  if ((longint'(MIN_ASSERT_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(REFCLK_STABLE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MIN_ASSERT_CYCLES or REFCLK_STABLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(REFCLK_STABLE_CYCLES - 1);

  logic deb_pin_n, deb_gpio_n, lock, req_n;

  pcie_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .in_dat(perst_pin_n), .out_dat(deb_pin_n)
  );

  pcie_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gpio (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .in_dat(gpio_perst_n), .out_dat(deb_gpio_n)
  );

  // Lock is only synchronised; any dropout must be seen immediately.
  pcie_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_lock (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .in_dat(refclk_locked), .out_dat(lock)
  );

  assign req_n = deb_pin_n & deb_gpio_n;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             rst_out_q, rst_out_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    evt_d     = evt_q;
    rst_out_d = (state_q == ST_RUN);
    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q != MIN_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (req_n) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (!req_n) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (lock) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!req_n) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (!lock) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!req_n || !lock) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          if (evt_q != EVT_SAT) evt_d = evt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      evt_q     <= '0;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      rst_out_q <= rst_out_d;
    end
  end

  // A single flop feeds both resets so they can never skew or diverge.
  assign pin_perst_n_reset_n     = rst_out_q;
  assign i_gpio_perst0_n_reset_n = rst_out_q;
  assign seq_state               = state_q;
  assign perst_event_cnt         = evt_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Scoreboard bench: stimulus queues expected state transitions (state, event count, cycle);
// a negedge monitor pops on every seq_state change and checks reset outputs every cycle.
module tb_pcie_perst_sequencer;
  import pcie_perst_seq_pkg::*;

  logic       clk_clk = 1'b0;
  logic       reset_reset, perst_pin_n, gpio_perst_n, refclk_locked;
  logic       pin_perst_n_reset_n, i_gpio_perst0_n_reset_n;
  logic [1:0] seq_state;
  logic [7:0] perst_event_cnt;

  typedef struct {
    logic [1:0] st;
    int         evt;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         failures = 0;
  int         cyc_n = 0;
  logic       rst_smp = 1'b1;
  logic       mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;
  logic       exp_out;

  always #5 clk_clk = ~clk_clk;

  pcie_perst_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .MIN_ASSERT_CYCLES(16),
    .REFCLK_STABLE_CYCLES(8), .CNT_W(8)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .perst_pin_n(perst_pin_n),
    .gpio_perst_n(gpio_perst_n), .refclk_locked(refclk_locked),
    .pin_perst_n_reset_n(pin_perst_n_reset_n),
    .i_gpio_perst0_n_reset_n(i_gpio_perst0_n_reset_n),
    .seq_state(seq_state), .perst_event_cnt(perst_event_cnt)
  );

  function automatic void chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, want, cyc_n);
    end
  endfunction

  task automatic expect_tr(input logic [1:0] st, input int evt, input int cyc);
    exp_t x;
    x.st = st; x.evt = evt; x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic goto(input int c);
    while (cyc_n < c) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // Release from reset (last reset edge = n) with inputs high and lock high.
  task automatic expect_startup(input int n);
    expect_tr(ST_WAIT_LOCK, 0, n + 16);
    expect_tr(ST_SETTLE,    0, n + 17);
    expect_tr(ST_RUN,       0, n + 25);
  endtask

  always @(posedge clk_clk) begin
    cyc_n++;
    rst_smp = reset_reset;
  end

  always @(negedge clk_clk) begin
    if (mon_en) begin
      exp_out = rst_smp ? 1'b0 : (prev_state == ST_RUN);
      chk("pin_rst_out", pin_perst_n_reset_n, exp_out);
      chk("gpio_rst_out", i_gpio_perst0_n_reset_n, exp_out);
      if (seq_state != prev_state) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transition got=%0d from=%0d cyc=%0d", seq_state, prev_state, cyc_n);
        end else begin
          e = exp_q.pop_front();
          chk("tr_state", seq_state, e.st);
          chk("tr_evt", perst_event_cnt, e.evt);
          chk("tr_cycle", cyc_n, e.cyc);
        end
      end
      prev_state = seq_state;
    end
  end

  initial begin
    int b, b2, b3, evt_exp;
    reset_reset = 1'b1; perst_pin_n = 1'b1; gpio_perst_n = 1'b1; refclk_locked = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("reset_state", seq_state, ST_ASSERT);
    chk("reset_pin_out", pin_perst_n_reset_n, 0);
    chk("reset_gpio_out", i_gpio_perst0_n_reset_n, 0);
    chk("reset_evt", perst_event_cnt, 0);

    // 1: clean power-up sequence
    reset_reset = 1'b0;
    prev_state  = ST_ASSERT;
    mon_en      = 1'b1;
    expect_startup(cyc_n);

    // 2: one-cycle PERST# pulse in RUN
    goto(31);
    b = cyc_n;
    perst_pin_n = 1'b0;
    expect_tr(ST_ASSERT,    1, b + 4);
    expect_tr(ST_WAIT_LOCK, 1, b + 20);
    expect_tr(ST_SETTLE,    1, b + 21);
    expect_tr(ST_RUN,       1, b + 29);
    goto(b + 1);
    perst_pin_n = 1'b1;

    // 3: 3-cycle high glitch while held in ASSERT must not release
    b2 = b + 32;
    goto(b2);
    perst_pin_n = 1'b0;
    expect_tr(ST_ASSERT, 2, b2 + 4);
    goto(b2 + 40);
    perst_pin_n = 1'b1;
    goto(b2 + 43);
    perst_pin_n = 1'b0;
    goto(b2 + 60);
    chk("glitch_held_assert", seq_state, ST_ASSERT);

    // 4: release, then a one-cycle lock dropout at settle count 5
    b3 = cyc_n;
    perst_pin_n = 1'b1;
    expect_tr(ST_WAIT_LOCK, 2, b3 + 7);
    expect_tr(ST_SETTLE,    2, b3 + 8);
    expect_tr(ST_WAIT_LOCK, 2, b3 + 14);
    expect_tr(ST_SETTLE,    2, b3 + 15);
    expect_tr(ST_RUN,       2, b3 + 23);
    goto(b3 + 11);
    refclk_locked = 1'b0;
    goto(b3 + 12);
    refclk_locked = 1'b1;
    goto(b3 + 25);

    // 5: 300 lock dropouts from RUN; event count saturates at 255
    evt_exp = 2;
    for (int i = 0; i < 300; i++) begin
      b = cyc_n;
      refclk_locked = 1'b0;
      if (evt_exp < 255) evt_exp++;
      expect_tr(ST_ASSERT,    evt_exp, b + 3);
      expect_tr(ST_WAIT_LOCK, evt_exp, b + 19);
      expect_tr(ST_SETTLE,    evt_exp, b + 20);
      expect_tr(ST_RUN,       evt_exp, b + 28);
      goto(b + 1);
      refclk_locked = 1'b1;
      goto(b + 28);
    end
    chk("evt_saturated", perst_event_cnt, 255);

    // 6: reset_reset asserted while in SETTLE
    b = cyc_n;
    refclk_locked = 1'b0;
    expect_tr(ST_ASSERT,    255, b + 3);
    expect_tr(ST_WAIT_LOCK, 255, b + 19);
    expect_tr(ST_SETTLE,    255, b + 20);
    goto(b + 1);
    refclk_locked = 1'b1;
    goto(b + 22);
    reset_reset = 1'b1;
    expect_tr(ST_ASSERT, 0, b + 23);
    goto(b + 23);
    reset_reset = 1'b0;
    chk("midreset_state", seq_state, ST_ASSERT);
    chk("midreset_pin_out", pin_perst_n_reset_n, 0);
    chk("midreset_gpio_out", i_gpio_perst0_n_reset_n, 0);
    chk("midreset_evt", perst_event_cnt, 0);
    expect_startup(b + 23);
    goto(b + 23 + 30);
    chk("all_transitions_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
